// File: rtl/char_mem_writer.sv
// char_mem_writer
// Write-side controller for the 7-bit character memory. Characters arrive
// over a valid/ready stream and are written to consecutive addresses from 0.
// A bulk clear fills every entry with FILL. A registered read port serves the
// display/lookup logic and is available in every state.
//
// Optional feature macro: CHAR_MEM_WRITER_ASCII_FILTER_EN
//   When defined, beats whose code is outside 0x20..0x7E (and not 0x0A) are
//   accepted but dropped. Dropped beats still end the frame if in_last is set.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a new frame (IDLE only)
//   clear     begin a bulk clear (IDLE only, wins over start)
//   in_valid  producer has a beat
//   in_ready  block accepts a beat this cycle (decode of state only)
//   in_data   character code
//   in_last   final beat of the frame
//   busy      state is not IDLE
//   done      one-cycle pulse at frame end
//   overflow  sticky, frame filled the memory before in_last
//   length    characters written in the current or last frame
//   rd_addr   readback address
//   rd_data   registered readback data (read-first on collision)
module char_mem_writer #(
  parameter int unsigned          ADDR_W = 16,
  parameter int unsigned          DATA_W = 7,
  parameter logic [DATA_W-1:0]    FILL   = 7'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   length,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] clr_ptr;

  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic [LEN_W-1:0]  length_nxt;
  logic              overflow_nxt;
  logic              in_ready_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              keep_c;

  // Decide whether an accepted beat is stored or silently dropped.
`ifdef CHAR_MEM_WRITER_ASCII_FILTER_EN
  always_comb begin
    keep_c = ((in_data >= DATA_W'('h20)) && (in_data <= DATA_W'('h7E))) ||
             (in_data == DATA_W'('h0A));
  end
`else
  always_comb begin
    keep_c = 1'b1;
  end
`endif

  // Next-state, datapath updates and memory write strobe.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    clr_ptr_nxt  = clr_ptr;
    length_nxt   = length;
    overflow_nxt = overflow;
    mem_we_c     = 1'b0;
    mem_waddr_c  = wr_ptr;
    mem_wdata_c  = in_data;

    case (state)
      S_IDLE: begin
        if (clear) begin
          state_nxt   = S_CLEAR;
          clr_ptr_nxt = '0;
        end else if (start) begin
          state_nxt    = S_WRITE;
          wr_ptr_nxt   = '0;
          length_nxt   = '0;
          overflow_nxt = 1'b0;
        end
      end

      S_WRITE: begin
        if (in_valid && in_ready) begin
          if (keep_c) begin
            mem_we_c   = 1'b1;
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            length_nxt = length + LEN_W'(1);
            if (in_last) begin
              state_nxt = S_DONE;
            end else if (length == LEN_W'(DEPTH - 1)) begin
              // Memory is full: stop before the pointer wraps onto address 0.
              overflow_nxt = 1'b1;
              state_nxt    = S_DONE;
            end
          end else if (in_last) begin
            state_nxt = S_DONE;
          end
        end
      end

      S_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr;
        mem_wdata_c = FILL;
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = S_IDLE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Status outputs are registered decodes of the next state, so they track
    // the state register exactly and never depend on in_valid.
    in_ready_nxt = (state_nxt == S_WRITE);
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = (state_nxt == S_DONE);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      clr_ptr  <= '0;
      length   <= '0;
      overflow <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      clr_ptr  <= clr_ptr_nxt;
      length   <= length_nxt;
      overflow <= overflow_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_char_mem_writer.sv
// tb_char_mem_writer
// Directed bench for char_mem_writer with ADDR_W=4 (DEPTH=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_char_mem_writer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 7;

  logic              clk;
  logic              rst;
  logic              start;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  int n_checks;
  int n_fail;

  char_mem_writer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FILL   (7'h20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .length   (length),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be accepted.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp);
    rd_addr = a;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int iter;
    int n;
    logic v;
    logic saw_done;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    rd_addr  = '0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_length",   32'(length),   32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    rst = 1'b0;
    tick();

    // Three-beat frame
    begin_frame();
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_busy",  32'(busy),     32'd1);
    send_beat(7'h41, 1'b0);
    send_beat(7'h42, 1'b0);
    send_beat(7'h43, 1'b1);
    check("t1_done",     32'(done),     32'd1);
    check("t1_ready_dn", 32'(in_ready), 32'd0);
    check("t1_length",   32'(length),   32'd3);
    check("t1_overflow", 32'(overflow), 32'd0);
    tick();
    check("t1_done_off", 32'(done), 32'd0);
    check("t1_idle",     32'(busy), 32'd0);
    read_check("t1_mem0", 4'd0, 7'h41);
    read_check("t1_mem1", 4'd1, 7'h42);
    read_check("t1_mem2", 4'd2, 7'h43);

    // Overflow: 17 beats offered, only 16 fit
    begin_frame();
    for (int i = 0; i < 16; i++) begin
      send_beat(7'(32'h50 + i), 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 7'h60;
    check("t2_ready17", 32'(in_ready), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_length",   32'(length),   32'd16);
    check("t2_done",     32'(done),     32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_ovf_hold", 32'(overflow), 32'd1);
    read_check("t2_mem0",  4'd0,  7'h50);
    read_check("t2_mem15", 4'd15, 7'h5F);

    // Clear with start in the same cycle: clear wins
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("t3_ready", 32'(in_ready), 32'd0);
    n = 0;
    saw_done = 1'b0;
    while (busy && n < 40) begin
      if (done) saw_done = 1'b1;
      n++;
      tick();
    end
    check("t3_busy_cycles", 32'(n), 32'd16);
    check("t3_no_done", 32'(saw_done), 32'd0);
    check("t3_length",  32'(length),   32'd16);
    check("t3_ovf",     32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_check("t3_fill", 4'(i), 7'h20);
    end

    // Random in_valid gaps, five beats
    begin_frame();
    k = 0;
    iter = 0;
    while (k < 5 && iter < 200) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = 7'(32'h61 + k);
      in_last  = (k == 4);
      tick();
      if (v) k++;
      iter++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_beats",  32'(k),      32'd5);
    check("t4_done",   32'(done),   32'd1);
    check("t4_length", 32'(length), 32'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      read_check("t4_mem", 4'(i), 7'(32'h61 + i));
    end
    read_check("t4_mem5_untouched", 4'd5, 7'h20);

    // Reset mid-frame
    begin_frame();
    send_beat(7'h71, 1'b0);
    send_beat(7'h72, 1'b0);
    rst = 1'b1;
    tick();
    check("t5_ready",  32'(in_ready), 32'd0);
    check("t5_busy",   32'(busy),     32'd0);
    check("t5_done",   32'(done),     32'd0);
    check("t5_ovf",    32'(overflow), 32'd0);
    check("t5_length", 32'(length),   32'd0);
    check("t5_rd",     32'(rd_data),  32'd0);
    rst = 1'b0;
    tick();
    begin_frame();
    send_beat(7'h33, 1'b1);
    check("t5_len1", 32'(length), 32'd1);
    tick();
    read_check("t5_mem0", 4'd0, 7'h33);
    read_check("t5_mem1", 4'd1, 7'h72);

`ifdef CHAR_MEM_WRITER_ASCII_FILTER_EN
    // Filtered beats are accepted but not stored
    begin_frame();
    send_beat(7'h41, 1'b0);
    send_beat(7'h07, 1'b0);
    send_beat(7'h0A, 1'b0);
    send_beat(7'h1B, 1'b1);
    check("t6_done",   32'(done),   32'd1);
    check("t6_length", 32'(length), 32'd2);
    tick();
    read_check("t6_mem0", 4'd0, 7'h41);
    read_check("t6_mem1", 4'd1, 7'h0A);
    read_check("t6_mem2", 4'd2, 7'h63);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
